// File: rtl/qdma_stm_c2h_gen_pkg.sv
// Shared types for the C2H stream generator: stub C2H header beat layout and the queued command.
package qdma_stm_c2h_gen_pkg;

    localparam int STM_QID_BITS   = 12;
    localparam int STM_FLOW_BITS  = 8;
    localparam int STM_TDEST_BITS = 16;
    localparam int STM_LEN_BITS   = 16;

    typedef struct packed {
        logic [STM_LEN_BITS-1:0] pkt_len;
        logic                    eot;
        logic                    usr_int;
        logic [13:0]             rsvd;
    } c2h_stub_tmh_t;

    typedef struct packed {
        logic [63:0]   cmp_data_0;
        c2h_stub_tmh_t tmh;
    } c2h_stub_cmp_t;

    typedef struct packed {
        c2h_stub_cmp_t             cmp;
        logic [STM_TDEST_BITS-1:0] tdest;
        logic [STM_FLOW_BITS-1:0]  flow_id;
        logic [STM_QID_BITS-1:0]   qid;
    } c2h_stub_hdr_beat_t;

    typedef struct packed {
        logic [STM_QID_BITS-1:0]   qid;
        logic [STM_FLOW_BITS-1:0]  flow_id;
        logic [STM_TDEST_BITS-1:0] tdest;
        logic [STM_LEN_BITS-1:0]   pkt_len;
        logic                      eot;
        logic [7:0]                seed;
    } stm_gen_cmd_t;

    // Header carries only the command fields; everything else is zero.
    function automatic c2h_stub_hdr_beat_t stm_gen_hdr(input stm_gen_cmd_t c);
        c2h_stub_hdr_beat_t h;
        h                 = '0;
        h.qid             = c.qid;
        h.flow_id         = c.flow_id;
        h.tdest           = c.tdest;
        h.cmp.tmh.pkt_len = c.pkt_len;
        h.cmp.tmh.eot     = c.eot;
        return h;
    endfunction

endpackage

// File: rtl/qdma_fifo_lut.sv
// Small LUT-based synchronous FIFO with a combinational (unregistered) read port.
module qdma_fifo_lut #(
    parameter int FIFO_DEPTH = 2,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_cnt;
    logic             w_wr;
    logic             w_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    assign w_wr      = i_wr_en & ~o_full;
    assign w_rd      = i_rd_en & ~o_empty;
    assign o_full    = (r_cnt == CNT_W'(FIFO_DEPTH));
    assign o_empty   = (r_cnt == {CNT_W{1'b0}});
    assign o_rd_data = r_mem[r_rptr];

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= {PTR_W{1'b0}};
            r_rptr <= {PTR_W{1'b0}};
            r_cnt  <= {CNT_W{1'b0}};
        end else begin
            if (w_wr) r_wptr <= ptr_inc(r_wptr);
            else      r_wptr <= r_wptr;
            if (w_rd) r_rptr <= ptr_inc(r_rptr);
            else      r_rptr <= r_rptr;
            case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= {WIDTH{1'b0}};
        end else if (w_wr) begin
            r_mem[r_wptr] <= i_wr_data;
        end else begin
            r_mem[r_wptr] <= r_mem[r_wptr];
        end
    end

endmodule

// File: rtl/qdma_stm_c2h_gen.sv
// C2H stream packet generator: each queued command becomes one header beat followed by
// seed-patterned payload beats on the C2H AXI-Stream.
module qdma_stm_c2h_gen
    import qdma_stm_c2h_gen_pkg::*;
#(
    parameter int MAX_DATA_WIDTH = 512,
    parameter int TDEST_BITS     = 16,
    parameter int QID_BITS       = 12,
    parameter int FLOW_BITS      = 8,
    parameter int LEN_BITS       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_vld,
    output logic                      cmd_rdy,
    input  logic [QID_BITS-1:0]       cmd_qid,
    input  logic [FLOW_BITS-1:0]      cmd_flow_id,
    input  logic [TDEST_BITS-1:0]     cmd_tdest,
    input  logic [LEN_BITS-1:0]       cmd_pkt_len,
    input  logic                      cmd_eot,
    input  logic [7:0]                cmd_seed,
    output logic [MAX_DATA_WIDTH-1:0] out_axis_tdata,
    output logic                      out_axis_tuser,
    output logic                      out_axis_tlast,
    output logic                      out_axis_tvalid,
    input  logic                      out_axis_tready,
    output logic                      busy,
    output logic [31:0]               pkt_cnt
);

    localparam int BYTES = MAX_DATA_WIDTH / 8;
    localparam int OFF_W = LEN_BITS + 1;
    localparam int HDR_W = $bits(c2h_stub_hdr_beat_t);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_PLD  = 2'd2;

    logic [1:0]                r_state;
    logic [LEN_BITS-1:0]       r_len;
    logic [7:0]                r_seed;
    logic [OFF_W-1:0]          r_off;
    logic [MAX_DATA_WIDTH-1:0] r_tdata;
    logic                      r_tuser;
    logic                      r_tlast;
    logic                      r_tvalid;
    logic [31:0]               r_pkt_cnt;

    stm_gen_cmd_t              w_cmd_in;
    stm_gen_cmd_t              w_cmd_head;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_fire;
    logic                      w_load_hdr;
    logic                      w_load_pld;
    logic                      w_go_idle;
    logic [MAX_DATA_WIDTH-1:0] w_hdr_data;
    logic [MAX_DATA_WIDTH-1:0] w_pld_data;
    logic                      w_pld_last;

    logic [1:0]                w_nxt_state;
    logic [LEN_BITS-1:0]       w_nxt_len;
    logic [7:0]                w_nxt_seed;
    logic [OFF_W-1:0]          w_nxt_off;
    logic [MAX_DATA_WIDTH-1:0] w_nxt_tdata;
    logic                      w_nxt_tuser;
    logic                      w_nxt_tlast;
    logic                      w_nxt_tvalid;

    // Byte k of the beat is packet byte (off + k); bytes past pkt_len are zero.
    function automatic logic [MAX_DATA_WIDTH-1:0] gen_beat(input logic [7:0]          seed,
                                                           input logic [OFF_W-1:0]    off,
                                                           input logic [LEN_BITS-1:0] len);
        logic [MAX_DATA_WIDTH-1:0] d;
        logic [OFF_W-1:0]          idx;
        d = {MAX_DATA_WIDTH{1'b0}};
        for (int k = 0; k < BYTES; k++) begin
            idx = off + OFF_W'(k);
            if (idx < {1'b0, len}) d[k*8 +: 8] = seed + idx[7:0];
            else                   d[k*8 +: 8] = 8'h00;
        end
        return d;
    endfunction

    assign w_push = cmd_vld & cmd_rdy;
    assign w_fire = r_tvalid & out_axis_tready;

    // Pack the command ports into the FIFO entry.
    always_comb begin
        w_cmd_in         = '0;
        w_cmd_in.qid     = cmd_qid;
        w_cmd_in.flow_id = cmd_flow_id;
        w_cmd_in.tdest   = cmd_tdest;
        w_cmd_in.pkt_len = cmd_pkt_len;
        w_cmd_in.eot     = cmd_eot;
        w_cmd_in.seed    = cmd_seed;
    end

    qdma_fifo_lut #(
        .FIFO_DEPTH (2),
        .WIDTH      ($bits(stm_gen_cmd_t))
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_push),
        .i_wr_data (w_cmd_in),
        .i_rd_en   (w_pop),
        .o_rd_data (w_cmd_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign w_hdr_data = {{(MAX_DATA_WIDTH-HDR_W){1'b0}}, stm_gen_hdr(w_cmd_head)};
    assign w_pld_data = gen_beat(r_seed, r_off, r_len);
    assign w_pld_last = ((r_off + OFF_W'(BYTES)) >= {1'b0, r_len});

    // Sequencing decisions: the next beat is chosen on the same cycle the current one handshakes.
    always_comb begin
        w_load_hdr = 1'b0;
        w_load_pld = 1'b0;
        w_go_idle  = 1'b0;
        case (r_state)
            S_IDLE: w_load_hdr = ~w_empty;
            S_HDR: begin
                w_go_idle  = w_fire & (r_len == {LEN_BITS{1'b0}});
                w_load_pld = w_fire & (r_len != {LEN_BITS{1'b0}});
            end
            S_PLD: begin
                w_load_hdr = w_fire & r_tlast & ~w_empty;
                w_go_idle  = w_fire & r_tlast & w_empty;
                w_load_pld = w_fire & ~r_tlast;
            end
            default: w_go_idle = 1'b1;
        endcase
        w_pop = w_load_hdr;
    end

    // Next-state and next-beat values.
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_len    = r_len;
        w_nxt_seed   = r_seed;
        w_nxt_off    = r_off;
        w_nxt_tdata  = r_tdata;
        w_nxt_tuser  = r_tuser;
        w_nxt_tlast  = r_tlast;
        w_nxt_tvalid = r_tvalid;
        if (w_load_hdr) begin
            w_nxt_state  = S_HDR;
            w_nxt_len    = w_cmd_head.pkt_len;
            w_nxt_seed   = w_cmd_head.seed;
            w_nxt_off    = {OFF_W{1'b0}};
            w_nxt_tdata  = w_hdr_data;
            w_nxt_tuser  = 1'b1;
            w_nxt_tlast  = (w_cmd_head.pkt_len == {LEN_BITS{1'b0}});
            w_nxt_tvalid = 1'b1;
        end else if (w_load_pld) begin
            w_nxt_state  = S_PLD;
            w_nxt_off    = r_off + OFF_W'(BYTES);
            w_nxt_tdata  = w_pld_data;
            w_nxt_tuser  = 1'b0;
            w_nxt_tlast  = w_pld_last;
            w_nxt_tvalid = 1'b1;
        end else if (w_go_idle) begin
            w_nxt_state  = S_IDLE;
            w_nxt_tdata  = {MAX_DATA_WIDTH{1'b0}};
            w_nxt_tuser  = 1'b0;
            w_nxt_tlast  = 1'b0;
            w_nxt_tvalid = 1'b0;
        end else begin
            w_nxt_state  = r_state;
        end
    end

    // State, working command and output beat registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_len    <= {LEN_BITS{1'b0}};
            r_seed   <= 8'h00;
            r_off    <= {OFF_W{1'b0}};
            r_tdata  <= {MAX_DATA_WIDTH{1'b0}};
            r_tuser  <= 1'b0;
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_len    <= w_nxt_len;
            r_seed   <= w_nxt_seed;
            r_off    <= w_nxt_off;
            r_tdata  <= w_nxt_tdata;
            r_tuser  <= w_nxt_tuser;
            r_tlast  <= w_nxt_tlast;
            r_tvalid <= w_nxt_tvalid;
        end
    end

    // Completed-packet counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    r_pkt_cnt <= 32'd0;
        else if (w_fire && r_tlast) r_pkt_cnt <= r_pkt_cnt + 32'd1;
        else                        r_pkt_cnt <= r_pkt_cnt;
    end

    assign cmd_rdy         = ~rst & ~w_full;
    assign busy            = (r_state != S_IDLE) | ~w_empty;
    assign pkt_cnt         = r_pkt_cnt;
    assign out_axis_tdata  = r_tdata;
    assign out_axis_tuser  = r_tuser;
    assign out_axis_tlast  = r_tlast;
    assign out_axis_tvalid = r_tvalid;

endmodule

// File: tb/tb_qdma_stm_c2h_gen.sv
// Self-checking bench for qdma_stm_c2h_gen: a queue-based packet model fed at command
// acceptance and compared against every output handshake.
module tb_qdma_stm_c2h_gen;
    import qdma_stm_c2h_gen_pkg::*;

    logic         clk;
    logic         rst;
    logic         cmd_vld;
    logic         cmd_rdy;
    logic [11:0]  cmd_qid;
    logic [7:0]   cmd_flow_id;
    logic [15:0]  cmd_tdest;
    logic [15:0]  cmd_pkt_len;
    logic         cmd_eot;
    logic [7:0]   cmd_seed;
    logic [511:0] out_axis_tdata;
    logic         out_axis_tuser;
    logic         out_axis_tlast;
    logic         out_axis_tvalid;
    logic         out_axis_tready;
    logic         busy;
    logic [31:0]  pkt_cnt;

    qdma_stm_c2h_gen dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_vld         (cmd_vld),
        .cmd_rdy         (cmd_rdy),
        .cmd_qid         (cmd_qid),
        .cmd_flow_id     (cmd_flow_id),
        .cmd_tdest       (cmd_tdest),
        .cmd_pkt_len     (cmd_pkt_len),
        .cmd_eot         (cmd_eot),
        .cmd_seed        (cmd_seed),
        .out_axis_tdata  (out_axis_tdata),
        .out_axis_tuser  (out_axis_tuser),
        .out_axis_tlast  (out_axis_tlast),
        .out_axis_tvalid (out_axis_tvalid),
        .out_axis_tready (out_axis_tready),
        .busy            (busy),
        .pkt_cnt         (pkt_cnt)
    );

    typedef struct {
        logic [511:0] d;
        logic         u;
        logic         l;
    } beat_t;

    beat_t  exp_q[$];
    int     hs_cyc[$];
    int     m_cnt;
    int     m_out;
    int     cyc;
    int     total;
    int     bad;
    bit     rnd_rdy;
    bit     prev_stall;
    beat_t  prev_beat;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Packet byte i is (seed + i) mod 256; bytes beyond len are zero.
    function automatic logic [511:0] beat_of(input int len, input int seed, input int b);
        logic [511:0] d;
        int idx;
        d = '0;
        for (int k = 0; k < 64; k++) begin
            idx = b * 64 + k;
            if (idx < len) d[k*8 +: 8] = 8'((seed + idx) % 256);
        end
        return d;
    endfunction

    function automatic logic [511:0] hdr_of(input logic [11:0] q, input logic [7:0] f,
                                            input logic [15:0] td, input logic [15:0] len,
                                            input logic eot);
        c2h_stub_hdr_beat_t h;
        h = '0;
        h.qid = q;
        h.flow_id = f;
        h.tdest = td;
        h.cmp.tmh.pkt_len = len;
        h.cmp.tmh.eot = eot;
        return 512'(h);
    endfunction

    // Output ready: always-on or 50% random.
    initial begin
        out_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Single compare process: check state, then advance the model for the coming edge.
    always @(negedge clk) begin
        beat_t e;
        beat_t cur;
        int    nb;
        cyc++;
        if (rst) begin
            exp_q.delete();
            m_cnt = 0;
            m_out = 0;
            prev_stall = 0;
        end else begin
            cur.d = out_axis_tdata;
            cur.u = out_axis_tuser;
            cur.l = out_axis_tlast;
            chk("pkt_cnt", pkt_cnt, 512'(m_cnt));
            chk("busy", busy, (m_out > 0));
            if (prev_stall) begin
                chk("stall_tvalid", out_axis_tvalid, 1'b1);
                chk("stall_tdata", cur.d, prev_beat.d);
                chk("stall_tuser", cur.u, prev_beat.u);
                chk("stall_tlast", cur.l, prev_beat.l);
            end
            if (out_axis_tvalid && out_axis_tready) begin
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("tdata", cur.d, e.d);
                    chk("tuser", cur.u, e.u);
                    chk("tlast", cur.l, e.l);
                    if (e.l) begin
                        m_cnt++;
                        m_out--;
                    end
                end
            end
            prev_stall = out_axis_tvalid && !out_axis_tready;
            prev_beat = cur;
            if (cmd_vld && cmd_rdy) begin
                e.d = hdr_of(cmd_qid, cmd_flow_id, cmd_tdest, cmd_pkt_len, cmd_eot);
                e.u = 1'b1;
                e.l = (cmd_pkt_len == 16'd0);
                exp_q.push_back(e);
                nb = (int'(cmd_pkt_len) + 63) / 64;
                for (int b = 0; b < nb; b++) begin
                    e.d = beat_of(int'(cmd_pkt_len), int'(cmd_seed), b);
                    e.u = 1'b0;
                    e.l = (b == nb - 1);
                    exp_q.push_back(e);
                end
                m_out++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the edge that accepted the command.
    task automatic send(input int len, input logic [7:0] sd, input logic eot);
        int t;
        cmd_vld     = 1'b1;
        cmd_qid     = 12'($urandom);
        cmd_flow_id = 8'($urandom);
        cmd_tdest   = 16'($urandom);
        cmd_pkt_len = 16'(len);
        cmd_eot     = eot;
        cmd_seed    = sd;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!cmd_rdy && t < 5000);
        if (!cmd_rdy) chk("cmd_accept_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || m_out != 0 || busy) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 20000) chk("drain_timeout", 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [511:0] d;
        int           n0;
        int           base;
        int           t;
        int           len;
        int           lens[8];
        lens = '{0, 1, 63, 64, 65, 127, 128, 129};
        total = 0;
        bad = 0;
        rnd_rdy = 0;
        rst = 1'b1;
        cmd_vld = 1'b0;
        cmd_qid = '0;
        cmd_flow_id = '0;
        cmd_tdest = '0;
        cmd_pkt_len = '0;
        cmd_eot = 1'b0;
        cmd_seed = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", out_axis_tvalid, 1'b0);
        chk("rst_tdata", out_axis_tdata, 512'd0);
        chk("rst_cmd_rdy", cmd_rdy, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pkt_cnt", pkt_cnt, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_cmd_rdy", cmd_rdy, 1'b1);

        // Hand-computed pattern values pinning the model.
        d = beat_of(64, 8'h10, 0);
        chk("m1_b0", d[7:0], 8'h10);
        chk("m1_b63", d[511:504], 8'h4F);
        d = beat_of(100, 8'hF0, 0);
        chk("m2_b15", d[127:120], 8'hFF);
        chk("m2_b16", d[135:128], 8'h00);
        chk("m2_b63", d[511:504], 8'h2F);
        d = beat_of(100, 8'hF0, 1);
        chk("m2_c0", d[7:0], 8'h30);
        chk("m2_c35", d[287:280], 8'h53);
        chk("m2_pad", d[511:288], 224'd0);

        send(64, 8'h10, 1'b0);
        cmd_vld = 1'b0;
        drain();
        chk("t1_pkt_cnt", pkt_cnt, 32'd1);

        send(100, 8'hF0, 1'b0);
        cmd_vld = 1'b0;
        drain();
        chk("t2_pkt_cnt", pkt_cnt, 32'd2);

        n0 = hs_cyc.size();
        send(0, 8'h55, 1'b1);
        cmd_vld = 1'b0;
        drain();
        chk("t3_beats", 32'(hs_cyc.size() - n0), 32'd1);
        chk("t3_pkt_cnt", pkt_cnt, 32'd3);

        // Three back-to-back commands stream without bubbles.
        base = int'(pkt_cnt);
        n0 = hs_cyc.size();
        send(128, 8'h01, 1'b0);
        send(128, 8'h02, 1'b0);
        send(128, 8'h03, 1'b0);
        chk("t4_cmd_rdy_full", cmd_rdy, 1'b0);
        cmd_vld = 1'b0;
        drain();
        chk("t4_beats", 32'(hs_cyc.size() - n0), 32'd9);
        if (hs_cyc.size() >= n0 + 9)
            chk("t4_span", 32'(hs_cyc[n0 + 8] - hs_cyc[n0]), 32'd8);
        chk("t4_pkt_cnt", 32'(int'(pkt_cnt) - base), 32'd3);

        rnd_rdy = 1;
        send(300, 8'hA7, 1'b1);
        cmd_vld = 1'b0;
        drain();

        for (int i = 0; i < 24; i++) begin
            len = ($urandom_range(0, 1) == 1) ? lens[$urandom_range(0, 7)] : int'($urandom_range(0, 400));
            send(len, 8'($urandom), 1'($urandom));
            cmd_vld = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        drain();
        rnd_rdy = 0;

        base = int'(pkt_cnt);
        send(65535, 8'hC3, 1'b0);
        cmd_vld = 1'b0;
        drain();
        chk("max_len_pkt_cnt", 32'(int'(pkt_cnt) - base), 32'd1);

        // Reset while the second payload beat is on the bus.
        n0 = hs_cyc.size();
        send(300, 8'h44, 1'b0);
        cmd_vld = 1'b0;
        t = 0;
        while (hs_cyc.size() < n0 + 2 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) chk("t6_wait_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_tvalid", out_axis_tvalid, 1'b0);
        chk("t6_tdata", out_axis_tdata, 512'd0);
        chk("t6_tlast", out_axis_tlast, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_pkt_cnt", pkt_cnt, 32'd0);
        chk("t6_cmd_rdy", cmd_rdy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(64, 8'h33, 1'b0);
        cmd_vld = 1'b0;
        drain();
        chk("t6_post_pkt_cnt", pkt_cnt, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
